br_fu: RTL and testbench

- Single-lane branch execution unit: the producer side of the branch-resolution record (done, take_branch, target, target_PC, NPC, ROB/FL/SQ/LQ indices) that the branch predictor consumes to detect mispredicts and drive rollback.
- Two instances sit in the FU stage, one per superscalar lane.
- Evaluates Alpha conditional/unconditional branches, computes the resolved next PC, and carries the fetch-time prediction through a 2-stage pipeline.
- Squashes in-flight work younger than an incoming rollback.

---
 rtl/br_fu.sv | 203 ++++++++++++++++++++
 tb/tb_br_fu.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_fu.sv
// Branch execution unit, one superscalar lane.
// Two-stage pipeline: S1 captures the issued branch and evaluates it, S2 registers the
// resolution record consumed by the branch predictor. S1 entries younger than an incoming
// rollback are dropped before they reach S2.
// Optional build macro BR_FU_STATS_EN adds saturating resolution/mispredict counters.
module br_fu #(
  parameter int unsigned NUM_ROB = 32,
  parameter int unsigned NUM_FL  = 32,
  parameter int unsigned NUM_LSQ = 8,
  localparam int unsigned RobW   = $clog2(NUM_ROB),
  localparam int unsigned FlW    = $clog2(NUM_FL),
  localparam int unsigned LsqW   = $clog2(NUM_LSQ)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [5:0]      issue_opcode,
  input  logic [20:0]     issue_disp,
  input  logic [63:0]     issue_ra_val,
  input  logic [63:0]     issue_rb_val,
  input  logic [63:0]     issue_NPC,
  input  logic [63:0]     issue_pred,
  input  logic [RobW-1:0] issue_ROB_idx,
  input  logic [FlW-1:0]  issue_FL_idx,
  input  logic [LsqW-1:0] issue_SQ_idx,
  input  logic [LsqW-1:0] issue_LQ_idx,
  input  logic            rollback_en,
  input  logic [RobW-1:0] ROB_rollback_idx,
  input  logic [RobW-1:0] ROB_tail_idx,
  output logic            out_done,
  output logic            out_take_branch,
  output logic [63:0]     out_target,
  output logic [63:0]     out_target_PC,
  output logic [63:0]     out_NPC,
  output logic [63:0]     out_link,
  output logic [RobW-1:0] out_ROB_idx,
  output logic [FlW-1:0]  out_FL_idx,
  output logic [LsqW-1:0] out_SQ_idx,
  output logic [LsqW-1:0] out_LQ_idx
`ifdef BR_FU_STATS_EN
  ,
  output logic [31:0]     stat_resolved,
  output logic [31:0]     stat_mispredict
`endif
);

  // Alpha branch-format opcodes (IR[31:26])
  localparam logic [5:0] OpJsr  = 6'h1A;
  localparam logic [5:0] OpBr   = 6'h30;
  localparam logic [5:0] OpBsr  = 6'h34;
  localparam logic [5:0] OpBlbc = 6'h38;
  localparam logic [5:0] OpBeq  = 6'h39;
  localparam logic [5:0] OpBlt  = 6'h3A;
  localparam logic [5:0] OpBle  = 6'h3B;
  localparam logic [5:0] OpBlbs = 6'h3C;
  localparam logic [5:0] OpBne  = 6'h3D;
  localparam logic [5:0] OpBge  = 6'h3E;
  localparam logic [5:0] OpBgt  = 6'h3F;

  typedef struct packed {
    logic [5:0]      opcode;
    logic [20:0]     disp;
    logic [63:0]     ra;
    logic [63:0]     rb;
    logic [63:0]     npc;
    logic [63:0]     pred;
    logic [RobW-1:0] rob;
    logic [FlW-1:0]  fl;
    logic [LsqW-1:0] sq;
    logic [LsqW-1:0] lq;
  } s1_t;

  logic        s1_valid_q;
  s1_t         s1_q;
  logic        accept;
  logic        squash;
  logic        advance;
  logic [RobW-1:0] age_s1;
  logic [RobW-1:0] age_rb;
  logic        take;
  logic [63:0] pc_rel_dest;
  logic [63:0] jsr_dest;
  logic [63:0] dest;
  logic [63:0] link;
  logic [63:0] target_pc;
  logic        ra_zero;
  logic        ra_neg;

  assign issue_ready = ~rollback_en;
  assign accept      = issue_valid & issue_ready;

  // Ages are distances back from the tail, wrapping at NUM_ROB; a smaller age is younger.
  assign age_s1  = ROB_tail_idx - s1_q.rob;
  assign age_rb  = ROB_tail_idx - ROB_rollback_idx;
  assign squash  = rollback_en & (age_s1 < age_rb);
  assign advance = s1_valid_q & ~squash;

  // S1 capture of the accepted issue
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_q <= '{opcode: issue_opcode, disp: issue_disp, ra: issue_ra_val,
                  rb: issue_rb_val, npc: issue_NPC, pred: issue_pred,
                  rob: issue_ROB_idx, fl: issue_FL_idx, sq: issue_SQ_idx,
                  lq: issue_LQ_idx};
      end
    end
  end

  assign ra_zero     = (s1_q.ra == 64'd0);
  assign ra_neg      = s1_q.ra[63];
  assign pc_rel_dest = s1_q.npc + {{41{s1_q.disp[20]}}, s1_q.disp, 2'b00};
  assign jsr_dest    = s1_q.rb & ~64'h3;

  // Branch direction, destination and link value from the S1 entry
  always_comb begin
    take = 1'b0;
    dest = pc_rel_dest;
    link = 64'd0;
    case (s1_q.opcode)
      OpBr, OpBsr: begin
        take = 1'b1;
        link = s1_q.npc;
      end
      OpJsr: begin
        take = 1'b1;
        dest = jsr_dest;
        link = s1_q.npc;
      end
      OpBlbc:  take = ~s1_q.ra[0];
      OpBeq:   take = ra_zero;
      OpBlt:   take = ra_neg;
      OpBle:   take = ra_neg | ra_zero;
      OpBlbs:  take = s1_q.ra[0];
      OpBne:   take = ~ra_zero;
      OpBge:   take = ~ra_neg;
      OpBgt:   take = ~ra_neg & ~ra_zero;
      default: take = 1'b0;
    endcase
    target_pc = take ? dest : s1_q.npc;
  end

  // S2 output register; idle cycles present an all-zero record
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_done        <= 1'b0;
      out_take_branch <= 1'b0;
      out_target      <= 64'd0;
      out_target_PC   <= 64'd0;
      out_NPC         <= 64'd0;
      out_link        <= 64'd0;
      out_ROB_idx     <= '0;
      out_FL_idx      <= '0;
      out_SQ_idx      <= '0;
      out_LQ_idx      <= '0;
    end else if (advance) begin
      out_done        <= 1'b1;
      out_take_branch <= take;
      out_target      <= s1_q.pred;
      out_target_PC   <= target_pc;
      out_NPC         <= s1_q.npc;
      out_link        <= link;
      out_ROB_idx     <= s1_q.rob;
      out_FL_idx      <= s1_q.fl;
      out_SQ_idx      <= s1_q.sq;
      out_LQ_idx      <= s1_q.lq;
    end else begin
      out_done        <= 1'b0;
      out_take_branch <= 1'b0;
      out_target      <= 64'd0;
      out_target_PC   <= 64'd0;
      out_NPC         <= 64'd0;
      out_link        <= 64'd0;
      out_ROB_idx     <= '0;
      out_FL_idx      <= '0;
      out_SQ_idx      <= '0;
      out_LQ_idx      <= '0;
    end
  end

`ifdef BR_FU_STATS_EN
  // Saturating counters over presented resolutions
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_resolved   <= 32'd0;
      stat_mispredict <= 32'd0;
    end else if (out_done) begin
      if (stat_resolved != 32'hFFFF_FFFF) begin
        stat_resolved <= stat_resolved + 32'd1;
      end
      if ((out_target != out_target_PC) && (stat_mispredict != 32'hFFFF_FFFF)) begin
        stat_mispredict <= stat_mispredict + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_br_fu.sv
// Self-checking bench for br_fu: table of branch vectors plus hand-written rollback and
// reset sequences, checked through a scoreboard keyed on the expected done cycle.
module tb_br_fu;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_opcode;
  logic [20:0] issue_disp;
  logic [63:0] issue_ra_val;
  logic [63:0] issue_rb_val;
  logic [63:0] issue_NPC;
  logic [63:0] issue_pred;
  logic [4:0]  issue_ROB_idx;
  logic [4:0]  issue_FL_idx;
  logic [2:0]  issue_SQ_idx;
  logic [2:0]  issue_LQ_idx;
  logic        rollback_en;
  logic [4:0]  ROB_rollback_idx;
  logic [4:0]  ROB_tail_idx;
  logic        out_done;
  logic        out_take_branch;
  logic [63:0] out_target;
  logic [63:0] out_target_PC;
  logic [63:0] out_NPC;
  logic [63:0] out_link;
  logic [4:0]  out_ROB_idx;
  logic [4:0]  out_FL_idx;
  logic [2:0]  out_SQ_idx;
  logic [2:0]  out_LQ_idx;
`ifdef BR_FU_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispredict;
`endif

  br_fu dut (
    .clock            (clock),
    .reset            (reset),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .issue_opcode     (issue_opcode),
    .issue_disp       (issue_disp),
    .issue_ra_val     (issue_ra_val),
    .issue_rb_val     (issue_rb_val),
    .issue_NPC        (issue_NPC),
    .issue_pred       (issue_pred),
    .issue_ROB_idx    (issue_ROB_idx),
    .issue_FL_idx     (issue_FL_idx),
    .issue_SQ_idx     (issue_SQ_idx),
    .issue_LQ_idx     (issue_LQ_idx),
    .rollback_en      (rollback_en),
    .ROB_rollback_idx (ROB_rollback_idx),
    .ROB_tail_idx     (ROB_tail_idx),
    .out_done         (out_done),
    .out_take_branch  (out_take_branch),
    .out_target       (out_target),
    .out_target_PC    (out_target_PC),
    .out_NPC          (out_NPC),
    .out_link         (out_link),
    .out_ROB_idx      (out_ROB_idx),
    .out_FL_idx       (out_FL_idx),
    .out_SQ_idx       (out_SQ_idx),
    .out_LQ_idx       (out_LQ_idx)
`ifdef BR_FU_STATS_EN
    ,
    .stat_resolved    (stat_resolved),
    .stat_mispredict  (stat_mispredict)
`endif
  );

  typedef struct {
    logic [5:0]  op;
    logic [20:0] disp;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [63:0] npc;
    logic [63:0] pred;
    logic        take;
    logic [63:0] tpc;
    logic [63:0] link;
  } vec_t;

  typedef struct {
    int          due;
    logic        take;
    logic [63:0] tpc;
    logic [63:0] pred;
    logic [63:0] npc;
    logic [63:0] link;
    logic [4:0]  rob;
    logic [4:0]  fl;
    logic [2:0]  sq;
    logic [2:0]  lq;
  } exp_t;

  localparam int NumVec = 16;
  vec_t vt [NumVec];
  exp_t sb [$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_res = 0;
  int   exp_mis = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  // Compare the presented record against the scoreboard head when it falls due
  always @(negedge clock) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      chk("done", {63'd0, out_done}, 64'd1);
      chk("take", {63'd0, out_take_branch}, {63'd0, mon_e.take});
      chk("target_PC", out_target_PC, mon_e.tpc);
      chk("target", out_target, mon_e.pred);
      chk("NPC", out_NPC, mon_e.npc);
      chk("link", out_link, mon_e.link);
      chk("tags", {45'd0, out_ROB_idx, out_FL_idx, out_SQ_idx, out_LQ_idx},
          {45'd0, mon_e.rob, mon_e.fl, mon_e.sq, mon_e.lq});
      exp_res++;
      if (mon_e.pred != mon_e.tpc) exp_mis++;
    end else begin
      chk("idle_done", {63'd0, out_done}, 64'd0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    issue_valid = 1'b0;
    rollback_en = 1'b0;
  endtask

  task automatic issue(input vec_t v, input logic [4:0] rob, input logic expect_done);
    exp_t e;
    issue_valid   = 1'b1;
    issue_opcode  = v.op;
    issue_disp    = v.disp;
    issue_ra_val  = v.ra;
    issue_rb_val  = v.rb;
    issue_NPC     = v.npc;
    issue_pred    = v.pred;
    issue_ROB_idx = rob;
    issue_FL_idx  = rob + 5'd3;
    issue_SQ_idx  = rob[2:0];
    issue_LQ_idx  = rob[2:0] + 3'd1;
    if (expect_done) begin
      e.due  = cyc + 2;
      e.take = v.take;
      e.tpc  = v.tpc;
      e.pred = v.pred;
      e.npc  = v.npc;
      e.link = v.link;
      e.rob  = rob;
      e.fl   = rob + 5'd3;
      e.sq   = rob[2:0];
      e.lq   = rob[2:0] + 3'd1;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sb.delete();
    exp_res = 0;
    exp_mis = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        op     disp       ra                     rb       npc                    pred     take tpc                    link
    vt[0]  = '{6'h39, 21'h10,    64'd0,                 64'd0,   64'h1004,              64'h1004, 1'b1, 64'h1044,              64'd0};
    vt[1]  = '{6'h3A, 21'h4,     64'h8000_0000_0000_0000, 64'd0, 64'h2000,              64'h2010, 1'b1, 64'h2010,              64'd0};
    vt[2]  = '{6'h3F, 21'h4,     64'h8000_0000_0000_0000, 64'd0, 64'h2004,              64'h2004, 1'b0, 64'h2004,              64'd0};
    vt[3]  = '{6'h1A, 21'h0,     64'd0,                 64'h2003, 64'h400,              64'h400,  1'b1, 64'h2000,              64'h400};
    vt[4]  = '{6'h3D, 21'h1FFFFF, 64'd5,                64'd0,   64'h100,               64'h100,  1'b1, 64'hFC,                64'd0};
    vt[5]  = '{6'h3B, 21'h100000, 64'd0,                64'd0,   64'h3000,              64'h3004, 1'b1, 64'hFFFF_FFFF_FFC0_3000, 64'd0};
    vt[6]  = '{6'h3E, 21'h8,     64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h500,               64'h520,  1'b0, 64'h500,               64'd0};
    vt[7]  = '{6'h38, 21'h1,     64'd2,                 64'd0,   64'h600,               64'h604,  1'b1, 64'h604,               64'd0};
    vt[8]  = '{6'h3C, 21'h1,     64'd2,                 64'd0,   64'h604,               64'h608,  1'b0, 64'h604,               64'd0};
    vt[9]  = '{6'h30, 21'h2,     64'd7,                 64'd0,   64'h700,               64'h708,  1'b1, 64'h708,               64'h700};
    vt[10] = '{6'h34, 21'h0,     64'd0,                 64'd0,   64'h800,               64'h0,    1'b1, 64'h800,               64'h800};
    vt[11] = '{6'h10, 21'h40,    64'd0,                 64'd0,   64'h900,               64'h900,  1'b0, 64'h900,               64'd0};
    vt[12] = '{6'h3F, 21'h3,     64'd1,                 64'd0,   64'hA00,               64'hA00,  1'b1, 64'hA0C,               64'd0};
    vt[13] = '{6'h39, 21'h1,     64'd0,                 64'd0,   64'hFFFF_FFFF_FFFF_FFFC, 64'd0,  1'b1, 64'd0,                 64'd0};
    vt[14] = '{6'h3A, 21'h5,     64'd0,                 64'd0,   64'hB00,               64'hB00,  1'b0, 64'hB00,               64'd0};
    vt[15] = '{6'h3B, 21'h5,     64'd1,                 64'd0,   64'hC00,               64'hC00,  1'b0, 64'hC00,               64'd0};

    reset = 1'b0;
    issue_valid = 1'b0;
    issue_opcode = '0;
    issue_disp = '0;
    issue_ra_val = '0;
    issue_rb_val = '0;
    issue_NPC = '0;
    issue_pred = '0;
    issue_ROB_idx = '0;
    issue_FL_idx = '0;
    issue_SQ_idx = '0;
    issue_LQ_idx = '0;
    rollback_en = 1'b0;
    ROB_rollback_idx = '0;
    ROB_tail_idx = '0;

    step();
    step();
    chk("rst_done", {63'd0, out_done}, 64'd0);
    chk("rst_target_PC", out_target_PC, 64'd0);
    chk("rst_link", out_link, 64'd0);
    chk("rst_ready", {63'd0, issue_ready}, 64'd1);
    reset = 1'b1;
    step();
    step();

    // Back-to-back table run
    for (int i = 0; i < NumVec; i++) begin
      step();
      issue(vt[i], i[4:0], 1'b1);
    end
    for (int i = 0; i < 4; i++) step();

    // Rollback older than S1 entry (tail=2, S1 idx 1, rollback idx 30): squashed
    ROB_tail_idx = 5'd2;
    step();
    issue(vt[0], 5'd1, 1'b0);
    step();
    rollback_en = 1'b1;
    ROB_rollback_idx = 5'd30;
    #1;
    chk("rb_ready", {63'd0, issue_ready}, 64'd0);
    for (int i = 0; i < 4; i++) step();

    // Same rollback with S1 idx 29 (older than rollback point): survives
    step();
    issue(vt[3], 5'd29, 1'b1);
    step();
    rollback_en = 1'b1;
    ROB_rollback_idx = 5'd30;
    for (int i = 0; i < 4; i++) step();

    // Equal index is never squashed
    step();
    issue(vt[9], 5'd30, 1'b1);
    step();
    rollback_en = 1'b1;
    ROB_rollback_idx = 5'd30;
    for (int i = 0; i < 4; i++) step();

    // Issue coinciding with rollback is refused
    step();
    issue(vt[12], 5'd5, 1'b0);
    rollback_en = 1'b1;
    ROB_rollback_idx = 5'd5;
    #1;
    chk("same_cyc_ready", {63'd0, issue_ready}, 64'd0);
    for (int i = 0; i < 4; i++) step();

    // Reset with both stages holding work: no done follows
    step();
    issue(vt[7], 5'd10, 1'b1);
    step();
    issue(vt[8], 5'd11, 1'b1);
    step();
    do_reset();
    #1;
    chk("midrst_done", {63'd0, out_done}, 64'd0);
    chk("midrst_target_PC", out_target_PC, 64'd0);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Recovery after reset: 3 resolutions, the first mispredicted
    for (int i = 0; i < 3; i++) begin
      step();
      issue(vt[i], 5'd20 + i[4:0], 1'b1);
    end
    for (int i = 0; i < 50 && sb.size() > 0; i++) step();
    step();
    chk("drain", 64'(sb.size()), 64'd0);

`ifdef BR_FU_STATS_EN
    chk("stat_resolved", {32'd0, stat_resolved}, 64'(exp_res));
    chk("stat_mispredict", {32'd0, stat_mispredict}, 64'(exp_mis));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
